// File: rtl/axi_slave_responder_if.sv
// AXI4 bus bundle for axi_slave_responder.
// Only the signals the responder uses are carried: full-width size and INCR bursts are implied.
interface axi_slave_responder_if #(
  parameter int AW = 64,
  parameter int DW = 512
);
  logic [AW-1:0]   S_AXI_AWADDR;
  logic            S_AXI_AWVALID;
  logic [7:0]      S_AXI_AWLEN;
  logic [3:0]      S_AXI_AWID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WLAST;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic [3:0]      S_AXI_BID;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic            S_AXI_ARVALID;
  logic [7:0]      S_AXI_ARLEN;
  logic [3:0]      S_AXI_ARID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic [3:0]      S_AXI_RID;
  logic            S_AXI_RVALID;
  logic            S_AXI_RLAST;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWLEN, S_AXI_AWID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WLAST,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BID, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARLEN, S_AXI_ARID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RID, S_AXI_RVALID, S_AXI_RLAST,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWLEN, S_AXI_AWID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WLAST,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BID, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARLEN, S_AXI_ARID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RID, S_AXI_RVALID, S_AXI_RLAST,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_slave_responder.sv
// AXI4 slave responder backed by a DEPTH-word RAM, INCR bursts, one write and
// one read outstanding. Every slave-driven handshake is gated by a *_en input.
// Optional macro AXI_SLAVE_COUNTERS_EN adds wr_count / rd_count outputs.
module axi_slave_responder #(
  parameter int AW    = 64,
  parameter int DW    = 512,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic awready_en,
  input  logic wready_en,
  input  logic bvalid_en,
  input  logic arready_en,
  input  logic rvalid_en,
  axi_slave_responder_if.slave s_axi
`ifdef AXI_SLAVE_COUNTERS_EN
  ,
  output logic [31:0] wr_count,
  output logic [31:0] rd_count
`endif
);
  localparam int NB = DW / 8;
  localparam int BW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // write side
  w_state_t        r_wstate, w_wstate_next;
  logic [IW-1:0]   r_widx;
  logic [7:0]      r_wlen, r_wbeat;
  logic [3:0]      r_wid;
  logic            r_werr, r_bvalid;
  logic            w_awready, w_wready, w_aw_fire, w_wr_fire, w_b_fire, w_wlast_beat;

  // read side
  r_state_t        r_rstate, w_rstate_next;
  logic [IW-1:0]   r_ridx, w_rd_idx;
  logic [7:0]      r_rlen, r_rbeat;
  logic [3:0]      r_rid;
  logic            r_rvalid;
  logic [DW-1:0]   r_rdata, w_rd_word;
  logic            w_arready, w_ar_fire, w_r_fire, w_rlast_beat;

  // address bits above/below the word index carry no meaning here
  logic [AW-1:0]   w_unused_addr;
  assign w_unused_addr = s_axi.S_AXI_AWADDR ^ s_axi.S_AXI_ARADDR;

  // READYs are combinational and forced low while reset is held
  assign w_awready    = (r_wstate == W_IDLE) & awready_en & resetn;
  assign w_wready     = (r_wstate == W_DATA) & wready_en & resetn;
  assign w_arready    = (r_rstate == R_IDLE) & arready_en & resetn;
  assign w_aw_fire    = w_awready & s_axi.S_AXI_AWVALID;
  assign w_wr_fire    = w_wready & s_axi.S_AXI_WVALID;
  assign w_b_fire     = r_bvalid & s_axi.S_AXI_BREADY;
  assign w_ar_fire    = w_arready & s_axi.S_AXI_ARVALID;
  assign w_r_fire     = r_rvalid & s_axi.S_AXI_RREADY;
  assign w_wlast_beat = (r_wbeat == r_wlen);
  assign w_rlast_beat = (r_rbeat == r_rlen);

  // a back-to-back read beat fetches the word after the one being accepted
  assign w_rd_idx = w_r_fire ? r_ridx + 1'b1 : r_ridx;

  // RAM split into byte lanes so WSTRB maps onto independent lane writes
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      // byte-lane write on an accepted W beat
      always_ff @(posedge clk) begin
        if (w_wr_fire && s_axi.S_AXI_WSTRB[gi]) r_mem[r_widx] <= s_axi.S_AXI_WDATA[gi*8 +: 8];
      end
      assign w_rd_word[gi*8 +: 8] = r_mem[w_rd_idx];
    end
  endgenerate

  // write FSM next-state
  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_fire) w_wstate_next = W_DATA;
      W_DATA:  if (w_wr_fire && w_wlast_beat) w_wstate_next = W_RESP;
      W_RESP:  if (w_b_fire) w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  // write FSM state, burst tracking and registered B response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate <= W_IDLE;
      r_widx   <= '0;
      r_wlen   <= '0;
      r_wbeat  <= '0;
      r_wid    <= '0;
      r_werr   <= 1'b0;
      r_bvalid <= 1'b0;
    end else begin
      r_wstate <= w_wstate_next;
      if (w_aw_fire) begin
        r_widx  <= s_axi.S_AXI_AWADDR[BW +: IW];
        r_wlen  <= s_axi.S_AXI_AWLEN;
        r_wid   <= s_axi.S_AXI_AWID;
        r_wbeat <= '0;
        r_werr  <= 1'b0;
      end
      if (w_wr_fire) begin
        // burst length comes from AWLEN; a misplaced WLAST only flags an error
        r_werr  <= r_werr | (s_axi.S_AXI_WLAST != w_wlast_beat);
        r_wbeat <= r_wbeat + 1'b1;
        r_widx  <= r_widx + 1'b1;
      end
      if (r_wstate == W_RESP) begin
        if (!r_bvalid && bvalid_en) r_bvalid <= 1'b1;
        else if (w_b_fire)          r_bvalid <= 1'b0;
      end
    end
  end

  // read FSM next-state
  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_fire) w_rstate_next = R_DATA;
      R_DATA:  if (w_r_fire && w_rlast_beat) w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  // read FSM state, beat tracking and registered R channel
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate <= R_IDLE;
      r_ridx   <= '0;
      r_rlen   <= '0;
      r_rbeat  <= '0;
      r_rid    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rstate <= w_rstate_next;
      if (w_ar_fire) begin
        r_ridx   <= s_axi.S_AXI_ARADDR[BW +: IW];
        r_rlen   <= s_axi.S_AXI_ARLEN;
        r_rid    <= s_axi.S_AXI_ARID;
        r_rbeat  <= '0;
        r_rvalid <= 1'b0;
      end else if (r_rstate == R_DATA) begin
        if (!r_rvalid) begin
          if (rvalid_en) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_word;
          end
        end else if (w_r_fire) begin
          if (w_rlast_beat) begin
            r_rvalid <= 1'b0;
          end else begin
            r_rbeat  <= r_rbeat + 1'b1;
            r_ridx   <= r_ridx + 1'b1;
            r_rvalid <= rvalid_en;
            if (rvalid_en) r_rdata <= w_rd_word;
          end
        end
      end
    end
  end

`ifdef AXI_SLAVE_COUNTERS_EN
  logic [31:0] r_wr_count, r_rd_count;
  // completed-transaction counters, wrapping naturally at 2^32
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else begin
      if (w_b_fire)                 r_wr_count <= r_wr_count + 1'b1;
      if (w_r_fire && w_rlast_beat) r_rd_count <= r_rd_count + 1'b1;
    end
  end
  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;
`endif

  assign s_axi.S_AXI_AWREADY = w_awready;
  assign s_axi.S_AXI_WREADY  = w_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = {r_werr, 1'b0};
  assign s_axi.S_AXI_BID     = r_wid;
  assign s_axi.S_AXI_ARREADY = w_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RLAST   = r_rvalid & w_rlast_beat;
  assign s_axi.S_AXI_RID     = r_rid;
  assign s_axi.S_AXI_RRESP   = 2'b00;
endmodule

// File: doc/axi_slave_responder.md
Name: axi_slave_responder

Overview:
AXI4 memory-mapped slave that answers the checker's AXI4 master stimulus. It is backed by a DEPTH-word internal RAM and supports INCR bursts, with one outstanding write and one outstanding read. Each handshake it drives (AWREADY, WREADY, BVALID, ARREADY, RVALID) is gated by a test-control input, so benches can throttle or stall each channel independently.

Parameters:
AW, 64, address width
DW, 512, data width (bytes = DW/8, power of 2)
DEPTH, 16, RAM words (power of 2, >=2)

Ports:
clk  in  1  clock
resetn  in  1  async active-low reset
awready_en  in  1  permits AWREADY
wready_en  in  1  permits WREADY
bvalid_en  in  1  permits BVALID rise
arready_en  in  1  permits ARREADY
rvalid_en  in  1  permits RVALID rise/continuation
S_AXI_AWADDR  in  AW  write address
S_AXI_AWVALID  in  1
S_AXI_AWLEN  in  8  beats-1
S_AXI_AWID  in  4
S_AXI_AWREADY  out  1
S_AXI_WDATA  in  DW
S_AXI_WSTRB  in  DW/8  byte enables
S_AXI_WVALID  in  1
S_AXI_WLAST  in  1
S_AXI_WREADY  out  1
S_AXI_BRESP  out  2
S_AXI_BID  out  4
S_AXI_BVALID  out  1
S_AXI_BREADY  in  1
S_AXI_ARADDR  in  AW
S_AXI_ARVALID  in  1
S_AXI_ARLEN  in  8
S_AXI_ARID  in  4
S_AXI_ARREADY  out  1
S_AXI_RDATA  out  DW
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RID  out  4
S_AXI_RVALID  out  1
S_AXI_RLAST  out  1
S_AXI_RREADY  in  1

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, resetn. Reset clears all FSMs and outputs to 0. RAM contents are not reset.
- Word index = addr[log2(DW/8) +: log2(DEPTH)]. It increments per beat and wraps mod DEPTH. Size is always full width, burst type is always INCR; SIZE/BURST/LOCK/CACHE/QOS/PROT are not ported.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY = awready_en (combinational). On handshake, latch index, AWLEN, AWID; clear beat count and err; go W_DATA.
  - W_DATA: WREADY = wready_en. Each handshake writes WDATA to RAM[index] per WSTRB byte lanes.
  - If WLAST != (beat==len) on any beat, set err.
  - The burst ends on beat==len regardless of WLAST; then go W_RESP.
  - W_RESP: BVALID is registered. It rises at the edge where bvalid_en=1 and holds until BREADY. BRESP = err ? 2'b10 : 2'b00; BID = latched ID. BVALID&BREADY -> W_IDLE.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY = arready_en. On handshake at edge k, latch index, len, ID; go R_DATA with RVALID=0.
  - R_DATA: when RVALID=0 and rvalid_en=1, the next edge sets RVALID=1 and RDATA=RAM[index]. First beat is therefore at edge k+1 at the earliest.
  - RVALID, RDATA, RLAST hold until RREADY.
  - On handshake, not last, rvalid_en=1: back-to-back beat with RDATA=RAM[index+1]. If rvalid_en=0, RVALID drops.
  - On handshake of the last beat: RVALID=0, go R_IDLE.
  - RLAST = RVALID & (beat==len).
- Read and write FSMs are independent. A same-cycle RAM write and RDATA load to the same index returns the old data.
- AW/AR may handshake in the same cycle.
- No READY is asserted outside its own state. Once asserted, a VALID output never drops before its handshake.
- Mid-burst reset aborts immediately, with no response issued.

Optional Feature:
AXI_SLAVE_COUNTERS_EN:
- Defined: adds 32-bit outputs wr_count and rd_count. wr_count increments on each B handshake; rd_count increments on each RLAST handshake. Both reset to 0 and wrap at 2^32.
- Undefined: ports and logic are absent.

Test Plan:
1. AWADDR=0x40, AWLEN=0, one beat WDATA=A5.., WSTRB=all-ones, all *_en=1 -> BVALID one cycle after the W handshake, BRESP=00, BID=AWID. ARADDR=0x40 -> RDATA=A5.., RLAST=1, RRESP=00.
2. 4-beat write at index DEPTH-2, then 4-beat read from the same address, RREADY=1 -> beats land at indices 14,15,0,1; read returns them in order; RLAST only on the 4th beat.
3. WLAST asserted on beat 2 of AWLEN=3 -> 4 beats still accepted, BRESP=2'b10.
4. Partial WSTRB=0x1 over preset data -> only byte 0 changes on readback.
5. Toggle wready_en/rvalid_en/bvalid_en randomly and hold BREADY/RREADY low for 5 cycles -> VALIDs stay stable, data never lost or duplicated.
6. resetn low during beat 2 of a read -> all outputs 0 asynchronously; a new AR after reset is accepted normally. With counters built in, both counts are 0.
